cca_feature_drain: RTL and testbench

- Sequences the output side of the CCA feature path.
- Captures completed-component bounding boxes, one per cycle, as the accumulator/CCA table retires them. Drops invalid or undersized boxes and buffers the rest in a small FIFO.
- Streams boxes out on a valid/ready interface and closes every frame with an end-of-frame record carrying the frame's blob count.
- The CCA side never sees backpressure. Loss is reported through a sticky overflow flag.

---
 rtl/cca_pkg.sv | 41 ++++
 rtl/cca_sync_fifo.sv | 59 +++++
 rtl/cca_feature_drain.sv | 147 ++++++++++++++
 tb/tb_cca_feature_drain.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cca_pkg.sv
`default_nettype none
// cca_pkg -- shared widths, field offsets, box helpers and marker FSM encoding for the CCA path.
// Revision: 1.0
package cca_pkg;

  localparam int CCA_X_BIT    = 9;
  localparam int CCA_Y_BIT    = 9;
  localparam int CCA_DATA_BIT = 2 * CCA_X_BIT + 2 * CCA_Y_BIT;

  // Packed box layout, MSB first: {minx, maxx, miny, maxy}
  function automatic int cca_maxy_lsb(input int xb, input int yb);
    return 0 * (xb + yb);
  endfunction

  function automatic int cca_miny_lsb(input int xb, input int yb);
    return yb + 0 * xb;
  endfunction

  function automatic int cca_maxx_lsb(input int xb, input int yb);
    return 2 * yb + 0 * xb;
  endfunction

  function automatic int cca_minx_lsb(input int xb, input int yb);
    return 2 * yb + xb;
  endfunction

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  // A cleared table entry holds min=all-ones, max=zero, so it fails this test too.
  function automatic logic box_valid(input int unsigned minx, input int unsigned maxx,
                                     input int unsigned miny, input int unsigned maxy);
    return (minx <= maxx) && (miny <= maxy);
  endfunction

  function automatic int unsigned box_extent(input int unsigned lo, input int unsigned hi);
    return hi - lo + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cca_sync_fifo.sv
`default_nettype none
// cca_sync_fifo -- flop-based synchronous FIFO, one write and one read per cycle, free-slot count out.
// Revision: 1.0
module cca_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int ABIT  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [ABIT:0]    free_o
);

  localparam int DEPTH = 1 << ABIT;
  localparam logic [ABIT:0] C_DEPTH = (ABIT + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ABIT-1:0]  wptr_q;
  logic [ABIT-1:0]  rptr_q;
  logic [ABIT:0]    count_q;
  logic             w_wr;
  logic             w_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == C_DEPTH);
  assign free_o  = C_DEPTH - count_q;
  assign w_rd    = rd_en_i & ~empty_o;
  // A write into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_wr    = wr_en_i & (~full_o | w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        mem_q[wptr_q] <= wr_data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (w_rd) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_q + {{ABIT{1'b0}}, w_wr} - {{ABIT{1'b0}}, w_rd};
    end
  end

  assign rd_data_o = mem_q[rptr_q];

endmodule
`default_nettype wire

// File: rtl/cca_feature_drain.sv
`default_nettype none
// cca_feature_drain -- filters retired CCA boxes into a FIFO and streams them out with per-frame count markers.
// Optional size filter: define CCA_SIZE_FILTER_EN.  Revision: 1.0
module cca_feature_drain
  import cca_pkg::*;
#(
  parameter int X_BIT     = CCA_X_BIT,
  parameter int Y_BIT     = CCA_Y_BIT,
  parameter int DATA_BIT  = CCA_DATA_BIT,
  parameter int FIFO_ABIT = 3,
  parameter int MAX_BLOBS = 32,
  parameter int CNT_BIT   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                feat_valid,
  input  logic [DATA_BIT-1:0] feat_data,
  input  logic                frame_end,
  input  logic [X_BIT-1:0]    min_w,
  input  logic [Y_BIT-1:0]    min_h,
  input  logic                clear_ovf,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_BIT-1:0] out_data,
  output logic                out_last,
  output logic [CNT_BIT-1:0]  blob_count,
  output logic                overflow,
  output logic                busy
);

  localparam int MINX_LSB = cca_minx_lsb(X_BIT, Y_BIT);
  localparam int MAXX_LSB = cca_maxx_lsb(X_BIT, Y_BIT);
  localparam int MINY_LSB = cca_miny_lsb(X_BIT, Y_BIT);
  localparam int MAXY_LSB = cca_maxy_lsb(X_BIT, Y_BIT);
  localparam logic [CNT_BIT-1:0]  C_MAX_BLOBS = CNT_BIT'(MAX_BLOBS);
  localparam logic [FIFO_ABIT:0]  C_TWO       = (FIFO_ABIT + 1)'(2);

  logic [0:0]          state_q, state_d;
  logic [CNT_BIT-1:0]  blob_q, blob_d;
  logic                ovf_q, ovf_d;

  logic [X_BIT-1:0]    w_minx, w_maxx;
  logic [Y_BIT-1:0]    w_miny, w_maxy;
  logic                w_box_ok, w_size_ok, w_pend, w_candidate, w_accept, w_marker;
  logic                w_lost;
  logic                w_wr_en, w_rd_en, w_empty, w_full;
  logic [DATA_BIT:0]   w_wr_data, w_head;
  logic [FIFO_ABIT:0]  w_free;

  assign w_minx = feat_data[MINX_LSB +: X_BIT];
  assign w_maxx = feat_data[MAXX_LSB +: X_BIT];
  assign w_miny = feat_data[MINY_LSB +: Y_BIT];
  assign w_maxy = feat_data[MAXY_LSB +: Y_BIT];

  assign w_box_ok = box_valid(32'(w_minx), 32'(w_maxx), 32'(w_miny), 32'(w_maxy));

`ifdef CCA_SIZE_FILTER_EN
  // One extra bit so a full-span box (0..2**X_BIT-1) does not wrap to zero width.
  logic [X_BIT:0] w_width;
  logic [Y_BIT:0] w_height;
  assign w_width   = (X_BIT + 1)'(box_extent(32'(w_minx), 32'(w_maxx)));
  assign w_height  = (Y_BIT + 1)'(box_extent(32'(w_miny), 32'(w_maxy)));
  assign w_size_ok = (w_width >= {1'b0, min_w}) && (w_height >= {1'b0, min_h});
`else
  logic w_unused_size;
  assign w_unused_size = ^{min_w, min_h};
  assign w_size_ok     = 1'b1;
`endif

  assign w_pend      = (state_q == ST_PEND);
  assign w_candidate = feat_valid & w_box_ok & w_size_ok;
  // The last free slot is held back so the frame marker can always land.
  assign w_accept    = w_candidate & ~w_pend & (blob_q < C_MAX_BLOBS) & (w_free >= C_TWO);
  assign w_marker    = w_pend & ~w_accept & (w_free != '0);
  assign w_lost      = (w_candidate & ~w_accept) | (frame_end & w_pend);

  assign w_wr_en   = w_accept | w_marker;
  assign w_wr_data = w_accept ? {1'b0, feat_data}
                              : {1'b1, {(DATA_BIT - CNT_BIT){1'b0}}, blob_q};
  assign w_rd_en   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (frame_end) state_d = ST_PEND;
      ST_PEND: if (w_marker)  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    blob_d = blob_q;
    if (w_marker) begin
      blob_d = '0;
    end else if (w_accept) begin
      blob_d = blob_q + 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (w_lost) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      blob_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blob_q  <= blob_d;
      ovf_q   <= ovf_d;
    end
  end

  cca_sync_fifo #(
    .WIDTH (DATA_BIT + 1),
    .ABIT  (FIFO_ABIT)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (w_wr_en),
    .wr_data_i (w_wr_data),
    .rd_en_i   (w_rd_en),
    .rd_data_o (w_head),
    .empty_o   (w_empty),
    .full_o    (w_full),
    .free_o    (w_free)
  );

  logic w_unused_full;
  assign w_unused_full = w_full;

  assign out_valid  = ~w_empty;
  assign out_data   = out_valid ? w_head[DATA_BIT-1:0] : '0;
  assign out_last   = out_valid & w_head[DATA_BIT];
  assign blob_count = blob_q;
  assign overflow   = ovf_q;
  assign busy       = ~w_empty | w_pend;

endmodule
`default_nettype wire

// File: tb/tb_cca_feature_drain.sv
`default_nettype none
// tb_cca_feature_drain -- directed stimulus with a queued scoreboard checked by an independent monitor.
module tb_cca_feature_drain;

  localparam int X_BIT     = 9;
  localparam int Y_BIT     = 9;
  localparam int DATA_BIT  = 36;
  localparam int FIFO_ABIT = 3;
  localparam int MAX_BLOBS = 32;
  localparam int CNT_BIT   = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                feat_valid;
  logic [DATA_BIT-1:0] feat_data;
  logic                frame_end;
  logic [X_BIT-1:0]    min_w;
  logic [Y_BIT-1:0]    min_h;
  logic                clear_ovf;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_BIT-1:0] out_data;
  logic                out_last;
  logic [CNT_BIT-1:0]  blob_count;
  logic                overflow;
  logic                busy;

  always #5 clk = ~clk;

  cca_feature_drain #(
    .X_BIT(X_BIT), .Y_BIT(Y_BIT), .DATA_BIT(DATA_BIT),
    .FIFO_ABIT(FIFO_ABIT), .MAX_BLOBS(MAX_BLOBS), .CNT_BIT(CNT_BIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .feat_valid(feat_valid), .feat_data(feat_data),
    .frame_end(frame_end), .min_w(min_w), .min_h(min_h), .clear_ovf(clear_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .blob_count(blob_count), .overflow(overflow), .busy(busy)
  );

  logic [DATA_BIT:0] exp_q[$];
  logic [DATA_BIT:0] sb_e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_BIT-1:0] box(input int minx, input int maxx,
                                              input int miny, input int maxy);
    return {X_BIT'(minx), X_BIT'(maxx), Y_BIT'(miny), Y_BIT'(maxy)};
  endfunction

  task automatic push(input logic last, input logic [DATA_BIT-1:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic fv, input logic [DATA_BIT-1:0] d, input logic fe);
    feat_valid = fv;
    feat_data  = d;
    frame_end  = fe;
    tick();
    feat_valid = 1'b0;
    frame_end  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    chk(name, 64'(busy), 64'(0));
  endtask

  task automatic pulse_clear();
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
  endtask

  // Monitor: a record transfers at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got last=%0b data=%0h expected no record", out_last, out_data);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_record", 64'({out_last, out_data}), 64'(sb_e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; feat_valid = 1'b0; feat_data = '0; frame_end = 1'b0;
    min_w = '0; min_h = '0; clear_ovf = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  64'(out_valid),  64'(0));
    chk("rst_out_data",   64'(out_data),   64'(0));
    chk("rst_out_last",   64'(out_last),   64'(0));
    chk("rst_blob_count", 64'(blob_count), 64'(0));
    chk("rst_overflow",   64'(overflow),   64'(0));
    chk("rst_busy",       64'(busy),       64'(0));
    rst_n = 1'b1;
    tick();

    // Three boxes then frame end, free-running sink.
    out_ready = 1'b1;
    push(1'b0, box(10, 20, 5, 9));     cyc(1'b1, box(10, 20, 5, 9), 1'b0);
    chk("t1_latency", 64'(out_valid), 64'(1));
    push(1'b0, box(0, 511, 0, 511));   cyc(1'b1, box(0, 511, 0, 511), 1'b0);
    push(1'b0, box(100, 101, 200, 300)); cyc(1'b1, box(100, 101, 200, 300), 1'b0);
    push(1'b1, DATA_BIT'(3));
    cyc(1'b0, '0, 1'b1);
    chk("t1_count_pend", 64'(blob_count), 64'(3));
    tick();
    chk("t1_count_clr", 64'(blob_count), 64'(0));
    wait_idle("t1_idle");

    // Stalled sink: 8 boxes into depth 8 keeps one slot for the marker.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) push(1'b0, box(i, i + 5, i, i + 2));
      cyc(1'b1, box(i, i + 5, i, i + 2), 1'b0);
    end
    chk("t2_overflow", 64'(overflow),   64'(1));
    chk("t2_count",    64'(blob_count), 64'(7));
    push(1'b1, DATA_BIT'(7));
    cyc(1'b0, '0, 1'b1);
    tick();
    chk("t2_hold_valid", 64'(out_valid), 64'(1));
    chk("t2_hold_last",  64'(out_last),  64'(0));
    chk("t2_hold_data",  64'(out_data),  64'(box(0, 5, 0, 2)));
    chk("t2_count_clr",  64'(blob_count), 64'(0));
    out_ready = 1'b1;
    wait_idle("t2_idle");
    pulse_clear();
    chk("t2_clear", 64'(overflow), 64'(0));

    // Box in the same cycle as frame_end belongs to the ending frame.
    push(1'b0, box(1, 2, 3, 4));   cyc(1'b1, box(1, 2, 3, 4), 1'b0);
    push(1'b0, box(7, 9, 8, 12));  cyc(1'b1, box(7, 9, 8, 12), 1'b1);
    push(1'b1, DATA_BIT'(2));
    wait_idle("t3_idle");
    chk("t3_count", 64'(blob_count), 64'(0));

    // Sentinel, undersized box, and a full-width box that must not wrap.
    min_w = X_BIT'(2);
    min_h = Y_BIT'(1);
    cyc(1'b1, box(511, 0, 511, 0), 1'b0);
`ifdef CCA_SIZE_FILTER_EN
    cyc(1'b1, box(3, 3, 4, 4), 1'b0);
    push(1'b0, box(0, 511, 7, 7)); cyc(1'b1, box(0, 511, 7, 7), 1'b0);
    push(1'b1, DATA_BIT'(1));
`else
    push(1'b0, box(3, 3, 4, 4));   cyc(1'b1, box(3, 3, 4, 4), 1'b0);
    push(1'b0, box(0, 511, 7, 7)); cyc(1'b1, box(0, 511, 7, 7), 1'b0);
    push(1'b1, DATA_BIT'(2));
`endif
    cyc(1'b0, '0, 1'b1);
    wait_idle("t4_idle");
    chk("t4_overflow", 64'(overflow), 64'(0));
    min_w = '0;
    min_h = '0;

    // Per-frame cap with fast drain.
    for (int i = 0; i < 40; i++) begin
      if (i < MAX_BLOBS) push(1'b0, box(i, i + 1, 2 * i, 2 * i + 3));
      cyc(1'b1, box(i, i + 1, 2 * i, 2 * i + 3), 1'b0);
    end
    chk("t5_overflow", 64'(overflow),   64'(1));
    chk("t5_count",    64'(blob_count), 64'(32));
    push(1'b1, DATA_BIT'(32));
    cyc(1'b0, '0, 1'b1);
    wait_idle("t5_idle");
    pulse_clear();
    chk("t5_clear", 64'(overflow), 64'(0));

    // Second frame_end while pending: set wins over a simultaneous clear.
    push(1'b1, DATA_BIT'(0));
    cyc(1'b0, '0, 1'b1);
    clear_ovf = 1'b1;
    cyc(1'b0, '0, 1'b1);
    clear_ovf = 1'b0;
    chk("t5_set_prio", 64'(overflow), 64'(1));
    wait_idle("t5b_idle");
    pulse_clear();
    chk("t5b_clear", 64'(overflow), 64'(0));

    // Asynchronous reset during a stalled transfer discards everything.
    out_ready = 1'b0;
    cyc(1'b1, box(1, 2, 3, 4), 1'b0);
    chk("t6_pre_valid", 64'(out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid),  64'(0));
    chk("t6_rst_data",  64'(out_data),   64'(0));
    chk("t6_rst_busy",  64'(busy),       64'(0));
    chk("t6_rst_count", 64'(blob_count), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("t6_post_valid", 64'(out_valid), 64'(0));

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
